// File: rtl/line_pkg.sv
// line_pkg: shared screen constants, coordinate/address types and writer FSM states
package line_pkg;
    localparam int SCREEN_W = 320;
    localparam int SCREEN_H = 240;
    typedef logic [8:0]  coord_x_t;
    typedef logic [7:0]  coord_y_t;
    typedef logic [16:0] fb_addr_t;
    typedef enum logic [2:0] {
        S_IDLE, S_PREP, S_LOAD, S_CAP, S_WRITE, S_STEP, S_FINISH, S_ABORT
    } state_t;
endpackage

// File: rtl/pixel_addr_calc.sv
// pixel_addr_calc: framebuffer word address y*320+x built from shifts, no multiplier
//   x_i    in   pixel x
//   y_i    in   pixel y
//   addr_o out  y*320+x truncated to ADDR_W
module pixel_addr_calc
    import line_pkg::*;
#(
    parameter int ADDR_W = 17
) (
    input  logic [8:0]        x_i,
    input  logic [7:0]        y_i,
    output logic [ADDR_W-1:0] addr_o
);
    coord_x_t x;
    coord_y_t y;
    assign x = x_i;
    assign y = y_i;
    assign addr_o = ADDR_W'(({10'd0, y} << 8) + ({10'd0, y} << 6) + {9'd0, x});
endmodule

// File: rtl/line_pixel_writer.sv
// line_pixel_writer: drives a line generator and writes one framebuffer pixel per point
//   cmd_*            line command in (valid/ready, ready only in IDLE)
//   busy/line_done/line_err/pixel_count  status
//   gen_*            line generator control out, gen_done/gen_bx/gen_by in
//   mem_*            req/ack pixel write port
//   Optional LINE_CLIP_EN: off-screen points skip the write and add clip_count.
module line_pixel_writer #(
    parameter int SCREEN_W  = 320,
    parameter int SCREEN_H  = 240,
    parameter int ADDR_W    = 17,
    parameter int COLOR_W   = 8,
    parameter int MAX_STEPS = 320
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               cmd_valid,
    output logic               cmd_ready,
    input  logic [8:0]         cmd_x0,
    input  logic [7:0]         cmd_y0,
    input  logic [8:0]         cmd_x1,
    input  logic [7:0]         cmd_y1,
    input  logic [COLOR_W-1:0] cmd_color,
    output logic               busy,
    output logic               line_done,
    output logic               line_err,
    output logic [8:0]         pixel_count,
`ifdef LINE_CLIP_EN
    output logic [8:0]         clip_count,
`endif
    output logic [8:0]         gen_start_x,
    output logic [7:0]         gen_start_y,
    output logic [8:0]         gen_end_x,
    output logic [7:0]         gen_end_y,
    output logic               gen_set_new,
    output logic               gen_draw_enable,
    input  logic               gen_done,
    input  logic [8:0]         gen_bx,
    input  logic [7:0]         gen_by,
    output logic               mem_wr,
    output logic [ADDR_W-1:0]  mem_addr,
    output logic [COLOR_W-1:0] mem_data,
    input  logic               mem_ack
);
    import line_pkg::*;
    localparam int SW = $clog2(MAX_STEPS + 1);
    state_t             state_q, state_d;
    coord_x_t           x0_q, x1_q;
    coord_y_t           y0_q, y1_q;
    logic [COLOR_W-1:0] color_q, data_q;
    logic [ADDR_W-1:0]  addr_q, addr_d;
    logic [8:0]         pix_q;
    logic [SW-1:0]      step_q;
    logic               accept, clip, limit;
    pixel_addr_calc #(.ADDR_W(ADDR_W)) u_addr (.x_i(gen_bx), .y_i(gen_by), .addr_o(addr_d));
`ifdef LINE_CLIP_EN
    logic [8:0] clip_q;
    assign clip       = 32'(gen_bx) >= SCREEN_W || 32'(gen_by) >= SCREEN_H;
    assign clip_count = clip_q;
`else
    assign clip = 1'b0;
`endif
    assign accept      = cmd_valid && cmd_ready;
    assign limit       = step_q == SW'(MAX_STEPS);
    assign gen_start_x = x0_q;
    assign gen_start_y = y0_q;
    assign gen_end_x   = x1_q;
    assign gen_end_y   = y1_q;
    assign mem_addr    = addr_q;
    assign mem_data    = data_q;
    assign pixel_count = pix_q;
    always_comb begin
        state_d         = state_q;
        cmd_ready       = state_q == S_IDLE;
        busy            = state_q != S_IDLE;
        gen_set_new     = state_q == S_LOAD;
        gen_draw_enable = state_q == S_STEP && !gen_done && !limit;
        mem_wr          = state_q == S_WRITE;
        line_done       = state_q == S_FINISH;
        line_err        = state_q == S_ABORT;
        unique case (state_q)
            S_IDLE:  state_d = cmd_valid ? S_PREP : S_IDLE;
            S_PREP:  state_d = S_LOAD;
            S_LOAD:  state_d = S_CAP;
            S_CAP:   state_d = clip ? S_STEP : S_WRITE;
            S_WRITE: state_d = mem_ack ? S_STEP : S_WRITE;
            S_STEP:  state_d = gen_done ? S_FINISH : limit ? S_ABORT : S_CAP;
            default: state_d = S_IDLE;
        endcase
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            x0_q    <= '0;
            y0_q    <= '0;
            x1_q    <= '0;
            y1_q    <= '0;
            color_q <= '0;
            addr_q  <= '0;
            data_q  <= '0;
            pix_q   <= '0;
            step_q  <= '0;
`ifdef LINE_CLIP_EN
            clip_q  <= '0;
`endif
        end else begin
            state_q <= state_d;
            if (accept) begin
                x0_q    <= cmd_x0;
                y0_q    <= cmd_y0;
                x1_q    <= cmd_x1;
                y1_q    <= cmd_y1;
                color_q <= cmd_color;
                pix_q   <= '0;
                step_q  <= '0;
`ifdef LINE_CLIP_EN
                clip_q  <= '0;
`endif
            end
            if (state_q == S_CAP) begin
                addr_q <= addr_d;
                data_q <= color_q;
            end
            if (mem_wr && mem_ack) pix_q <= pix_q + 9'd1;
            if (gen_draw_enable) step_q <= step_q + 1'b1;
`ifdef LINE_CLIP_EN
            if (state_q == S_CAP && clip) clip_q <= clip_q + 9'd1;
`endif
        end
    end
endmodule

// File: doc/line_pixel_writer.md
Name: line_pixel_writer

Overview:
- Consumer and controller for the line-generator coordinate interface.
- Accepts line commands (endpoints and colour) over a valid/ready handshake.
- Sequences the generator through set_new / draw_enable, takes each produced (bx, by), and writes one framebuffer pixel per point over a req/ack memory port.
- Sits between the drawing command source and the frame-buffer SRAM controller.

Parameters:
- SCREEN_W, 320, framebuffer width in pixels; also the row stride.
- SCREEN_H, 240, framebuffer height in pixels.
- ADDR_W, 17, framebuffer word-address width.
- COLOR_W, 8, pixel data width.
- MAX_STEPS, 320, draw_enable pulses allowed per line before abort.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- cmd_valid  in  1  command offered.
- cmd_ready  out  1  block can accept a command; high only in IDLE.
- cmd_x0  in  9  start x.
- cmd_y0  in  8  start y.
- cmd_x1  in  9  end x.
- cmd_y1  in  8  end y.
- cmd_color  in  COLOR_W  pixel colour.
- busy  out  1  high in every state except IDLE.
- line_done  out  1  one-cycle pulse when a line completes normally.
- line_err  out  1  one-cycle pulse when a line is aborted by the step guard.
- pixel_count  out  9  pixels written for the last or current line.
- gen_start_x  out  9  generator start x.
- gen_start_y  out  8  generator start y.
- gen_end_x  out  9  generator end x.
- gen_end_y  out  8  generator end y.
- gen_set_new  out  1  load generator with the start point.
- gen_draw_enable  out  1  advance generator one point.
- gen_done  in  1  generator has reached the end point (combinational).
- gen_bx  in  9  generator current x.
- gen_by  in  8  generator current y.
- mem_wr  out  1  write request.
- mem_addr  out  ADDR_W  write address.
- mem_data  out  COLOR_W  write data.
- mem_ack  in  1  write accepted.

Behaviour:
- Reset: state IDLE; cmd_ready=1; all other outputs 0, including the gen_* coordinates, mem_addr, mem_data and pixel_count.
- Command accept:
  - A command is accepted on an edge where cmd_valid && cmd_ready.
  - The command is latched into registers.
  - gen_start_* / gen_end_* are driven from the latch and held stable until return to IDLE. The generator registers its gradient and evaluates done from these inputs, so they must not change mid-line.
  - pixel_count clears to 0 on accept.
  - cmd_valid while busy is ignored.
- FSM: IDLE -> PREP -> LOAD -> CAP -> WRITE -> STEP -> {CAP | FINISH | ABORT} -> IDLE.
  - PREP: one cycle; lets the generator register its gradient from the new endpoints.
  - LOAD: gen_set_new=1 for exactly one cycle.
  - CAP: latch mem_addr = gen_by*SCREEN_W + gen_bx (truncated to ADDR_W) and mem_data = colour.
  - WRITE: mem_wr=1, with addr/data stable, until mem_ack is sampled high. Ack in the first WRITE cycle gives a 1-cycle write. On ack, pixel_count increments.
  - STEP:
    - If gen_done, go to FINISH.
    - Else if the step counter equals MAX_STEPS, go to ABORT.
    - Else gen_draw_enable=1 for one cycle, increment the step counter, go to CAP.
  - FINISH: line_done=1 for one cycle, then IDLE.
  - ABORT: line_err=1 for one cycle, then IDLE.
- Latency:
  - First mem_wr is high in the 4th cycle after the accepting edge.
  - With 0-wait ack, each further pixel takes 3 cycles (CAP, WRITE, STEP).
- mem_ack while mem_wr=0 is ignored.
- gen_set_new and gen_draw_enable are never high together, and never high in IDLE.
- A start point equal to the end point writes exactly one pixel, then line_done.
- Reset mid-line: the FSM returns to IDLE immediately. An in-flight mem_wr drops with no completion pulse, and gen_* outputs return to 0.

Optional Feature:
- Macro LINE_CLIP_EN.
- Defined:
  - In CAP, a point with gen_bx >= SCREEN_W or gen_by >= SCREEN_H skips WRITE and goes straight to STEP.
  - Extra port clip_count (out, 9) counts skipped points; it clears on accept.
  - pixel_count does not count skipped points.
- Undefined:
  - All points are written, with the address truncated to ADDR_W.
  - No clip_count port.

Decomposition:
- Package line_pkg:
  - SCREEN_W / SCREEN_H constants.
  - Typedefs coord_x_t (9b), coord_y_t (8b), fb_addr_t.
  - State enum for the FSM.
- Sub-module pixel_addr_calc: combinational y*320+x computed as (y<<8)+(y<<6)+x, with no multiplier. It is also reused by the future scan-out reader.

Test Plan:
- Horizontal line cmd (10,5)->(13,5), generator model attached, mem_ack tied high -> writes to addrs 1610, 1611, 1612, 1613; pixel_count=4; one line_done pulse.
- Vertical line (2,0)->(2,2) -> addrs 2, 322, 642; gen_set_new seen once; gen_draw_enable pulsed exactly twice.
- Single point (7,7)->(7,7) -> exactly one write at addr 2247; line_done the cycle after STEP; zero draw_enable pulses.
- mem_ack delayed 3 cycles per write on (0,0)->(1,1) -> mem_wr held 4 cycles per pixel with addr/data stable; addrs 0 and 321.
- gen_done forced 0 with MAX_STEPS=320 -> exactly 320 draw_enable pulses, 321 writes, line_err pulse, no line_done, cmd_ready back high.
- rst asserted during the 2nd WRITE of a 4-pixel line -> next cycle state IDLE, mem_wr=0, cmd_ready=1; a new command afterwards completes normally.
